// File: rtl/encoder4to2_sync.sv
// Synchronised, debounced 4-to-2 priority encoder with a valid/ready output handshake.
// Optional macro ENCODER4TO2_MULTI_ERR_EN adds the 'multi' flag for multi-line presses.
module encoder4to2_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] D,
    output logic [1:0] Y,
    output logic       valid,
    input  logic       ready,
    output logic       busy
`ifdef ENCODER4TO2_MULTI_ERR_EN
    ,
    output logic       multi
`endif
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESENT  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cap_q, cap_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] state_q, state_d;
    logic [1:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       multi_q, multi_d;

    function automatic logic [1:0] prio(input logic [3:0] v);
        if (v[3])      prio = 2'b11;
        else if (v[2]) prio = 2'b10;
        else if (v[1]) prio = 2'b01;
        else           prio = 2'b00;
    endfunction

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        multi_d = multi_q;
        if (!en) begin
            // Disable wins over every state, including a same-edge handshake.
            state_d = ST_IDLE;
            valid_d = 1'b0;
            multi_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q != 4'b0000) begin
                        state_d = ST_DEBOUNCE;
                        cap_d   = sync2_q;
                        cnt_d   = 8'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (sync2_q == 4'b0000) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (sync2_q != cap_q) begin
                        cap_d = sync2_q;
                        cnt_d = 8'd1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_PRESENT;
                        y_d     = prio(cap_q);
                        valid_d = 1'b1;
                        multi_d = ((cap_q & (cap_q - 4'd1)) != 4'b0000);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_PRESENT: begin
                    if (valid_q && ready) begin
                        state_d = ST_RELEASE;
                        valid_d = 1'b0;
                        multi_d = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (sync2_q != 4'b0000) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            sync1_q <= D;
            sync2_q <= sync1_q;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            multi_q <= multi_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
    assign busy  = busy_q;
`ifdef ENCODER4TO2_MULTI_ERR_EN
    assign multi = multi_q;
`else
    logic unused_multi;
    assign unused_multi = multi_q;
`endif

endmodule

// File: tb/tb_encoder4to2_sync.sv
// Directed bench for encoder4to2_sync: expected codes are queued at each press and
// compared when valid rises; ENCODER4TO2_MULTI_ERR_EN also checks the multi flag.
module tb_encoder4to2_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] D;
    logic [1:0] Y;
    logic       valid;
    logic       ready;
    logic       busy;
`ifdef ENCODER4TO2_MULTI_ERR_EN
    logic       multi;
`endif

    int unsigned nchecks = 0;
    int unsigned nerrors = 0;
    logic        valid_prev = 1'b0;
    logic [2:0]  exp_q[$];

    always #5 clk = ~clk;

    encoder4to2_sync #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .D     (D),
        .Y     (Y),
        .valid (valid),
        .ready (ready),
        .busy  (busy)
`ifdef ENCODER4TO2_MULTI_ERR_EN
        ,
        .multi (multi)
`endif
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {Y, multi} for a press of pattern v.
    task automatic push_press(input logic [3:0] v);
        logic [1:0] y;
        logic       m;
        if (v[3])      y = 2'b11;
        else if (v[2]) y = 2'b10;
        else if (v[1]) y = 2'b01;
        else           y = 2'b00;
        m = ($countones(v) > 1);
        exp_q.push_back({y, m});
    endtask

    // One clock; sample 1 time unit after the edge and score any new code.
    task automatic tick();
        logic [2:0] e;
        @(posedge clk);
        #1;
        if (valid && !valid_prev) begin
            check("code_expected", {3'b000, (exp_q.size() != 0)}, 4'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("code_Y", {2'b00, Y}, {2'b00, e[2:1]});
`ifdef ENCODER4TO2_MULTI_ERR_EN
                check("code_multi", {3'b000, multi}, {3'b000, e[0]});
`endif
            end
        end
        valid_prev = valid;
    endtask

    // D was driven just after an edge: valid must rise on the 6th edge, not earlier.
    task automatic expect_valid_at6(input string tag);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check({tag, "_early"}, {3'b000, valid}, 4'd0);
        end
        tick();
        check({tag, "_at6"}, {3'b000, valid}, 4'd1);
        check({tag, "_busy"}, {3'b000, busy}, 4'd1);
    endtask

    task automatic handshake_and_release();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("hs_valid", {3'b000, valid}, 4'd0);
        D = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        check("rel_idle", {3'b000, busy}, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        D     = 4'b0000;
        ready = 1'b0;
        #1;
        check("rst_Y", {2'b00, Y}, 4'd0);
        check("rst_valid", {3'b000, valid}, 4'd0);
        check("rst_busy", {3'b000, busy}, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", {3'b000, busy}, 4'd0);

        // Basic press, held with ready low.
        en = 1'b1;
        D  = 4'b0100;
        push_press(4'b0100);
        expect_valid_at6("press");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {3'b000, valid}, 4'd1);
            check("hold_Y", {2'b00, Y}, 4'b0010);
        end

        // Handshake while D stays held: no repeat code, busy stays in RELEASE.
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("hs_valid_fall", {3'b000, valid}, 4'd0);
        check("hs_busy", {3'b000, busy}, 4'd1);
        for (int i = 0; i < 10; i++) tick();
        check("held_busy", {3'b000, busy}, 4'd1);
        check("held_novalid", {3'b000, valid}, 4'd0);

        // Release: S reaches 0 on the 2nd edge, busy falls 4 edges later.
        D = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        check("rel_busy_hold", {3'b000, busy}, 4'd1);
        tick();
        check("rel_busy_fall", {3'b000, busy}, 4'd0);

        // Bounce on D[0] every 2 cycles, then settle.
        for (int k = 0; k < 5; k++) begin
            D = 4'b0001;
            tick();
            check("bounce_novalid", {3'b000, valid}, 4'd0);
            tick();
            check("bounce_novalid", {3'b000, valid}, 4'd0);
            D = 4'b0000;
            tick();
            check("bounce_novalid", {3'b000, valid}, 4'd0);
            tick();
            check("bounce_novalid", {3'b000, valid}, 4'd0);
        end
        D = 4'b0001;
        push_press(4'b0001);
        expect_valid_at6("bounce");
        handshake_and_release();

        // Multiple lines: highest priority wins.
        D = 4'b1011;
        push_press(4'b1011);
        expect_valid_at6("prio");
        check("prio_Y", {2'b00, Y}, 4'b0011);
        handshake_and_release();

        // Disable during PRESENT discards the code; Y keeps its value.
        D = 4'b0010;
        push_press(4'b0010);
        expect_valid_at6("dis");
        en = 1'b0;
        D  = 4'b0000;
        tick();
        check("dis_valid", {3'b000, valid}, 4'd0);
        check("dis_busy", {3'b000, busy}, 4'd0);
        check("dis_Y_kept", {2'b00, Y}, 4'b0001);
        tick();
        tick();
        en = 1'b1;
        tick();

        // en falling together with the handshake goes to IDLE, not RELEASE.
        D = 4'b0100;
        push_press(4'b0100);
        expect_valid_at6("simul");
        en    = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("simul_valid", {3'b000, valid}, 4'd0);
        check("simul_busy", {3'b000, busy}, 4'd0);
        D = 4'b0000;
        tick();
        tick();
        en = 1'b1;
        tick();

        // Asynchronous reset mid-DEBOUNCE.
        D = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        check("deb_busy", {3'b000, busy}, 4'd1);
        check("deb_Y_prev", {2'b00, Y}, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_Y", {2'b00, Y}, 4'd0);
        check("arst_valid", {3'b000, valid}, 4'd0);
        check("arst_busy", {3'b000, busy}, 4'd0);
        D = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        D = 4'b1000;
        push_press(4'b1000);
        expect_valid_at6("post_rst");
        handshake_and_release();

        check("queue_empty", exp_q.size() == 0 ? 4'd1 : 4'd0, 4'd1);
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/encoder4to2_sync.md
Name: encoder4to2_sync

Overview:
- Sequential 4-to-2 priority encoder, the encode-side counterpart of the team's 2-to-4 decoder.
- Takes four asynchronous request lines (e.g. buttons or board switches) and synchronises and debounces them.
- Presents the index of the highest active line as a 2-bit code, with a valid/ready handshake to downstream logic.
- Emits one code per press; a new code is accepted only after all lines release.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a press is accepted, and again before a release is accepted. Legal range 2..255. Counter width is 8 bits.

Ports:
- clk, input, 1: single system clock; all flops on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: synchronous block enable, active high.
- D, input, 4: raw asynchronous request lines; D[3] has highest priority.
- Y, output, 2: encoded index of the highest set bit of the debounced vector.
- valid, output, 1: Y holds a new code.
- ready, input, 1: downstream accepts the code.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - Y=2'b00, valid=0, busy=0.
  - FSM in IDLE.
  - Both synchroniser stages, capture register and counter all 0.
- Synchroniser: D passes through 2 flop stages to form S. All decisions use S only.
- FSM states: IDLE, DEBOUNCE, PRESENT, RELEASE. All state, Y, valid and busy are registered.
- IDLE:
  - en=1 and S!=0 -> DEBOUNCE; capture C<=S, cnt<=1.
  - Otherwise stay in IDLE.
- DEBOUNCE:
  - S!=C and S!=0 -> C<=S, cnt<=1, stay in DEBOUNCE.
  - S==0 -> IDLE.
  - S==C and cnt==DEBOUNCE_CYCLES-1 -> PRESENT; Y<=priority(C); valid<=1.
  - Otherwise cnt<=cnt+1.
- PRESENT:
  - Y and valid are held stable until valid&&ready is sampled.
  - On the handshake edge -> RELEASE; valid<=0 on that same edge.
  - Input changes are ignored while in PRESENT.
- RELEASE:
  - S==0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
  - Any S!=0 resets the release count to 0.
  - No new code is produced until RELEASE completes, so holding a line generates no repeat.
- Priority encoding: D3 -> 2'b11, D2 -> 2'b10, D1 -> 2'b01, D0 -> 2'b00.
- Latency: D stable from edge 0 gives valid high after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- Disable: en=0 in any state -> IDLE on the next edge, valid<=0, counter cleared. Y keeps its last value. An un-handshaken code is discarded.
- Simultaneous events:
  - en falling on the same edge as valid&&ready: the transfer is counted as done, and the FSM goes to IDLE, not RELEASE.
  - ready while valid=0 has no effect.
- Reset mid-operation: immediate return to the reset values regardless of state. No code is emitted after reset until a full new debounce completes.
- busy = (state!=IDLE), registered with the state.

Optional Feature:
- Macro: ENCODER4TO2_MULTI_ERR_EN.
- Defined:
  - Extra output port multi, 1 bit, reset 0.
  - multi is loaded with the valid load and is 1 when C has more than one bit set. It holds with Y and clears with valid.
  - Y still reports the highest-priority line.
- Undefined: port absent; multiple presses are resolved silently by priority.

Test Plan:
- Reset, then D=4'b0100 held, en=1, ready=0, DEBOUNCE_CYCLES=4:
  - valid rises after edge 6 with Y=2'b10.
  - valid and Y stay unchanged while ready=0.
- Handshake and release: from the previous state, ready=1 for one cycle:
  - valid falls on that edge and busy stays 1.
  - Release D=0; busy falls 4 cycles after S reaches 0.
  - Holding D through the whole test produces no second valid.
- Bounce: D toggles 4'b0001/0 every 2 cycles for 20 cycles, then stays 4'b0001:
  - No valid during toggling.
  - valid with Y=2'b00 exactly 6 edges after the last toggle.
- Priority with ENCODER4TO2_MULTI_ERR_EN defined: D=4'b1011 -> Y=2'b11, multi=1.
  - Bench without the macro: Y=2'b11 and no multi port.
- Disable/reset mid-operation:
  - en=0 during PRESENT -> valid=0 and busy=0 next edge.
  - rst_n pulsed low mid-DEBOUNCE -> all outputs 0 immediately, asynchronously.
  - After release, a fresh press takes the full 6 edges.
